// File: rtl/motor_cmd_pkg.sv
// Shared types and constants for the motor command sequencer.
package motor_cmd_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DUTY_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ARG = 2'd1,
    EXEC     = 2'd2
  } state_t;

  localparam logic [NIB_W-1:0] OP_NOP       = 4'h0;
  localparam logic [NIB_W-1:0] OP_SET_SPEED = 4'h1;
  localparam logic [NIB_W-1:0] OP_STOP      = 4'h2;
  localparam logic [NIB_W-1:0] OP_SHOW      = 4'h3;
  localparam logic [NIB_W-1:0] OP_CLR_ERR   = 4'h4;

  localparam int unsigned STATUS_MOTOR_ON   = 0;
  localparam int unsigned STATUS_AWAIT_ARG  = 1;
  localparam int unsigned STATUS_RAMPING    = 2;
  localparam int unsigned STATUS_STICKY_ERR = 3;

endpackage

// File: rtl/pwm_gen.sv
// 16-step PWM generator; duty is sampled only at the period boundary.
module pwm_gen
  import motor_cmd_pkg::*;
#(
  parameter int unsigned PWM_DIV = 64
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_reset,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              force_off_i,
  output logic              pwm_o
);

  localparam int unsigned      PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] latched_q, latched_d;
  logic              pwm_q, pwm_d;
  logic              adv_c;

  // Prescaler, period counter, boundary latch and compare; force_off overrides immediately.
  always_comb begin
    adv_c     = (pre_q == PRE_LAST);
    pre_d     = adv_c ? '0 : pre_q + PRE_W'(1);
    cnt_d     = adv_c ? cnt_q + DUTY_W'(1) : cnt_q;
    latched_d = latched_q;
    if (adv_c && (cnt_q == '1)) begin
      latched_d = duty_i;
    end
    if (force_off_i) begin
      latched_d = '0;
    end
    pwm_d = !force_off_i && (cnt_d < latched_d);
  end

  // State registers.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      latched_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_cmd_controller.sv
// Two-nibble command sequencer driving ramped motor PWM, display and status.
module motor_cmd_controller
  import motor_cmd_pkg::*;
#(
  parameter int unsigned RAMP_DIV       = 50000,
  parameter int unsigned PWM_DIV        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             FPGA_clk,
  input  logic             FPGA_reset,
  input  logic [NIB_W-1:0] spi_data_in,
  input  logic             spi_valid_in,
  output logic             motor_pwm_out,
  output logic [NIB_W-1:0] display_nibble_out,
  output logic             display_update_out,
  output logic [3:0]       status_out,
  output logic             cmd_error_out
);

  localparam int unsigned       RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam int unsigned       TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic [NIB_W-1:0]  opcode_q;
  logic [NIB_W-1:0]  arg_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              awaiting_q;
  logic              sticky_q;
  logic              cmd_error_q;
  logic [NIB_W-1:0]  disp_q;
  logic              disp_upd_q;

  logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DUTY_W-1:0] current_q, current_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              ramping_q, ramping_d;
  logic              motor_on_q, motor_on_d;

  logic              exec_c;
  logic              set_speed_c;
  logic              stop_c;
  logic              ramp_tick_c;

  assign exec_c      = (state_q == EXEC);
  assign set_speed_c = exec_c && (opcode_q == OP_SET_SPEED);
  assign stop_c      = exec_c && (opcode_q == OP_STOP);

  // Frame FSM: nibble assembly, timeout, opcode execution and error/display outputs.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      arg_q       <= '0;
      to_cnt_q    <= '0;
      awaiting_q  <= 1'b0;
      sticky_q    <= 1'b0;
      cmd_error_q <= 1'b0;
      disp_q      <= '0;
      disp_upd_q  <= 1'b0;
    end else begin
      cmd_error_q <= 1'b0;
      disp_upd_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spi_valid_in) begin
            opcode_q   <= spi_data_in;
            to_cnt_q   <= '0;
            state_q    <= WAIT_ARG;
            awaiting_q <= 1'b1;
          end
        end
        WAIT_ARG: begin
          if (spi_valid_in) begin
            arg_q      <= spi_data_in;
            state_q    <= EXEC;
            awaiting_q <= 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            state_q     <= IDLE;
            awaiting_q  <= 1'b0;
            cmd_error_q <= 1'b1;
            sticky_q    <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        EXEC: begin
          case (opcode_q)
            OP_NOP, OP_SET_SPEED, OP_STOP: begin
            end
            OP_SHOW: begin
              disp_q     <= arg_q;
              disp_upd_q <= 1'b1;
            end
            OP_CLR_ERR: begin
              sticky_q <= 1'b0;
            end
            default: begin
              cmd_error_q <= 1'b1;
              sticky_q    <= 1'b1;
            end
          endcase
          // A strobe on the execute cycle is the next opcode, never dropped.
          if (spi_valid_in) begin
            opcode_q   <= spi_data_in;
            to_cnt_q   <= '0;
            state_q    <= WAIT_ARG;
            awaiting_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          awaiting_q <= 1'b0;
        end
      endcase
    end
  end

  // Ramp divider and duty stepping; STOP overrides a coincident tick.
  always_comb begin
    ramp_tick_c = (ramp_cnt_q == RAMP_LAST);
    ramp_cnt_d  = ramp_tick_c ? '0 : ramp_cnt_q + RAMP_W'(1);
    target_d    = target_q;
    current_d   = current_q;
    if (set_speed_c) begin
      target_d = arg_q;
    end
    if (ramp_tick_c) begin
      if (current_q < target_d) begin
        current_d = current_q + DUTY_W'(1);
      end else if (current_q > target_d) begin
        current_d = current_q - DUTY_W'(1);
      end
    end
    if (stop_c) begin
      current_d = '0;
      target_d  = '0;
    end
    ramping_d  = (current_d != target_d);
    motor_on_d = (current_d != '0);
  end

  // Ramp and duty-derived status registers.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      ramp_cnt_q <= '0;
      current_q  <= '0;
      target_q   <= '0;
      ramping_q  <= 1'b0;
      motor_on_q <= 1'b0;
    end else begin
      ramp_cnt_q <= ramp_cnt_d;
      current_q  <= current_d;
      target_q   <= target_d;
      ramping_q  <= ramping_d;
      motor_on_q <= motor_on_d;
    end
  end

  pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm_gen (
    .FPGA_clk    (FPGA_clk),
    .FPGA_reset  (FPGA_reset),
    .duty_i      (current_q),
    .force_off_i (stop_c),
    .pwm_o       (motor_pwm_out)
  );

  assign status_out[STATUS_STICKY_ERR] = sticky_q;
  assign status_out[STATUS_RAMPING]    = ramping_q;
  assign status_out[STATUS_AWAIT_ARG]  = awaiting_q;
  assign status_out[STATUS_MOTOR_ON]   = motor_on_q;

  assign display_nibble_out = disp_q;
  assign display_update_out = disp_upd_q;
  assign cmd_error_out      = cmd_error_q;

endmodule

// File: doc/motor_cmd_controller.md
Name: motor_cmd_controller

Overview:
- Command sequencer between the SPI slave nibble stream and the board actuators.
- Assembles two-nibble frames (opcode, argument) from the SPI slave's 4-bit data/valid pulses.
- Executes each frame: configures a ramped motor PWM duty, drives the 7-seg display nibble, and maintains a 4-bit status word returned to the Arduino over MISO.
- Sits between Spi_slave_module and the motor pin / hex_to_7seg display register in the FPGA top level.

Parameters:
- RAMP_DIV, 50000: FPGA_clk cycles per ramp step of the current duty (±1).
- PWM_DIV, 64: FPGA_clk cycles per PWM counter increment.
- TIMEOUT_CYCLES, 1000000: maximum cycles allowed between opcode and argument nibbles.

Ports:
- FPGA_clk  in  1  system clock.
- FPGA_reset  in  1  reset, asynchronous, active-high.
- spi_data_in  in  4  nibble from SPI slave.
- spi_valid_in  in  1  one-cycle strobe; spi_data_in is valid when high.
- motor_pwm_out  out  1  PWM drive to the motor.
- display_nibble_out  out  4  value for the hex-to-7seg decoder.
- display_update_out  out  1  one-cycle strobe; capture display_nibble_out.
- status_out  out  4  {sticky_err, ramping, awaiting_arg, motor_on}, to the SPI reply.
- cmd_error_out  out  1  one-cycle strobe on a bad or timed-out frame.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; current_duty = target_duty = latched_duty = 0; all counters 0; sticky_err = 0.
- FSM IDLE:
  - spi_valid_in: store opcode, clear timeout counter, go to WAIT_ARG.
- FSM WAIT_ARG:
  - spi_valid_in: store arg, go to EXEC.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no valid: go to IDLE, pulse cmd_error_out, set sticky_err.
- FSM EXEC (exactly 1 cycle): apply the opcode, return to IDLE.
  - spi_valid_in during EXEC is taken as a new opcode; go to WAIT_ARG instead of IDLE. No nibble is ever dropped.
- Opcodes:
  - 0x0 NOP: no effect.
  - 0x1 SET_SPEED: target_duty = arg.
  - 0x2 STOP: target_duty = current_duty = 0 immediately; arg ignored.
  - 0x3 SHOW: display_nibble_out = arg, display_update_out pulses for 1 cycle.
  - 0x4 CLR_ERR: sticky_err = 0.
  - 0x5–0xF: no state change except error reporting; pulse cmd_error_out, set sticky_err.
- Latency: effects of the applied frame are visible on outputs in the cycle after EXEC, i.e. 2 clocks after the argument strobe.
- Ramp:
  - Free-running divider generates a tick every RAMP_DIV cycles.
  - On tick: current_duty increments if below target, decrements if above, holds if equal.
  - SET_SPEED mid-ramp retargets without resetting the divider.
  - STOP takes priority over a coincident tick.
- PWM:
  - Prescaler advances a 4-bit counter every PWM_DIV cycles; the counter wraps 15→0, giving a period of 16·PWM_DIV.
  - latched_duty = current_duty, loaded only when the counter wraps to 0, so there are no mid-period glitches.
  - motor_pwm_out = (pwm_cnt < latched_duty), registered.
  - Duty 0 gives constant low; duty 15 gives 15/16 high.
  - STOP forces latched_duty = 0 and motor_pwm_out = 0 within 1 cycle, without waiting for the period end.
- status_out (registered):
  - bit3 = sticky_err.
  - bit2 = (current_duty != target_duty).
  - bit1 = (state == WAIT_ARG).
  - bit0 = (current_duty != 0).
- Simultaneous error and CLR_ERR cannot occur: each frame carries one opcode.
- Timeout and arg strobe in the same cycle: the arg wins and the frame executes.
- Reset asserted mid-frame or mid-ramp returns every register to its reset value immediately; the partial frame is discarded.
- Width rules: all duty values are 4 bits unsigned, saturating at 0 and 15. Ramp steps never overshoot the target.

Decomposition:
- Package motor_cmd_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT_ARG, EXEC} state_t.
  - Opcode localparams OP_NOP..OP_CLR_ERR (4-bit).
  - STATUS_* bit-index constants.
- Sub-module pwm_gen: parameter PWM_DIV; inputs duty[3:0] and force_off; output pwm. Contains the prescaler, period counter and boundary latch.
- The FSM, ramp and status logic stay in motor_cmd_controller.

Test Plan:
Bench parameters: RAMP_DIV=4, PWM_DIV=1, TIMEOUT_CYCLES=32.
- Reset: assert FPGA_reset mid-clock → all outputs 0 asynchronously; status_out=0000.
- Nibbles 0x3, 0xA → display_nibble_out=0xA, display_update_out high for exactly 1 cycle, 2 clocks after the second strobe.
- Nibbles 0x1, 0xF → status_out=0101 during the ramp; duty reaches 15 after 15 ticks (~60 cycles), then status_out=0001; PWM high 15 of every 16 cycles.
- Ramp to duty 8, then nibbles 0x2, 0x0 → motor_pwm_out=0 within 1 cycle after EXEC; status_out=0000.
- Nibble 0x1 with no second nibble for 32 cycles → cmd_error_out pulse, status_out=1000. Then 0x4, 0x0 → status_out=0000.
- Nibbles 0x7, 0x3 → error pulse, no duty or display change. A new opcode strobe arriving on the EXEC cycle is accepted (status bit1=1).
